multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle RV32I core. It replaces the single-cycle decode path by sequencing one shared ALU and one unified instruction/data memory over several cycles per instruction. It drives every datapath select and write enable, and stalls on a memory ready handshake. Supported instructions are lw, sw, R-type ALU, I-type ALU, beq, bne and jal. Any other opcode traps.

---
 rtl/riscv_ctrl_pkg.sv | 25 ++
 rtl/alu_decoder.sv | 20 ++
 rtl/multicycle_ctrl.sv | 132 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: state, opcode, ALU and immediate encodings for the multi-cycle RV32I control path
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, TRAP
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: funct3/funct7b5 to ALUControl for R- and I-type ops, flags the unsupported sltu
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_r,
  output logic [2:0] alu_ctl,
  output logic       illegal
);
  always_comb
    alu_ctl = funct3 == 3'b000 ? ((is_r && funct7b5) ? ALU_SUB : ALU_ADD) :
              funct3 == 3'b001 ? ALU_SLL :
              funct3 == 3'b010 ? ALU_SLT :
              funct3 == 3'b100 ? ALU_XOR :
              funct3 == 3'b101 ? ALU_SRL :
              funct3 == 3'b110 ? ALU_OR  :
              funct3 == 3'b111 ? ALU_AND : ALU_ADD;
  assign illegal = funct3 == 3'b011;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing the shared ALU and unified memory of the multi-cycle RV32I core
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int STATE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            Zero,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [2:0]      ALUControl,
  output logic [1:0]      ImmSrc,
  output logic            instr_done,
  output logic            trap
);
  logic [STATE_W-1:0] state;
  state_t cur, nxt;
  logic [2:0] alu_ctl;
  logic illegal, pc_w, mem_w, ir_w, reg_w, done;
  assign cur = state_t'(state);
  alu_decoder u_alu_dec (
    .funct3  (funct3),
    .funct7b5(funct7b5),
    .is_r    (cur == EXECUTER),
    .alu_ctl (alu_ctl),
    .illegal (illegal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= STATE_W'(FETCH);
    else state <= STATE_W'(nxt);
  always_comb begin
    nxt = cur;
    pc_w = 1'b0;
    mem_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    done = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUControl = ALU_ADD;
    trap = 1'b0;
    case (cur)
      FETCH: begin
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        ir_w = mem_ready;
        pc_w = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
              op == OP_R   ? EXECUTER :
              op == OP_I   ? EXECUTEI :
              op == OP_BR  ? BRANCH :
              op == OP_JAL ? JAL : TRAP;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        nxt = op == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        nxt = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = 1'b1;
        done = 1'b1;
        nxt = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w = 1'b1;
        done = mem_ready;
        nxt = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = cur == EXECUTEI ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        nxt = illegal ? TRAP : ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        done = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUControl = ALU_SUB;
        pc_w = Zero ^ funct3[0];
        done = 1'b1;
        nxt = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w = 1'b1;
        nxt = ALUWB;
      end
      TRAP: trap = 1'b1;
      default: nxt = FETCH;
    endcase
  end
  always_comb
    ImmSrc = op == OP_SW  ? IMM_S :
             op == OP_BR  ? IMM_B :
             op == OP_JAL ? IMM_J : IMM_I;
  // reset gates the enables directly so FETCH's mem_ready-driven writes cannot fire while held in reset
  assign PCWrite    = pc_w  & rst_n;
  assign MemWrite   = mem_w & rst_n;
  assign IRWrite    = ir_w  & rst_n;
  assign RegWrite   = reg_w & rst_n;
  assign instr_done = done  & rst_n;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle vectors plus hand-written trap and reset sequences
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [17:0] outs;
  int errors = 0, checks = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .trap(trap)
  );

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, instr_done, trap};

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z, rdy;
    logic [17:0] x;
  } vec_t;
  vec_t tab[$];

  function automatic logic [17:0] e(input logic pcw, adr, mw, ir, rw, input logic [1:0] rs, a, b,
                                    input logic [2:0] alu, input logic [1:0] imm, input logic dn, tr);
    return {pcw, adr, mw, ir, rw, rs, a, b, alu, imm, dn, tr};
  endfunction
  function automatic logic [17:0] f_fetch(input logic r, input logic [1:0] imm);
    return e(r, 0, 0, r, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [17:0] f_dec(input logic [1:0] imm);
    return e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [17:0] f_wb(input logic [1:0] imm);
    return e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
  endfunction

  task automatic v(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, rdy, input logic [17:0] x);
    tab.push_back('{o, f3, f7, z, rdy, x});
  endtask
  task automatic rtype(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    v(RT, f3, f7, 0, 1, f_fetch(1, 2'b00));
    v(RT, f3, f7, 0, 1, f_dec(2'b00));
    v(RT, f3, f7, 0, 1, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 0, 0));
    v(RT, f3, f7, 0, 1, f_wb(2'b00));
  endtask
  task automatic itype(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    v(IT, f3, f7, 0, 1, f_fetch(1, 2'b00));
    v(IT, f3, f7, 0, 1, f_dec(2'b00));
    v(IT, f3, f7, 0, 1, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 0, 0));
    v(IT, f3, f7, 0, 1, f_wb(2'b00));
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, rdy);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = rdy;
  endtask
  task automatic chk(input string n, input logic [17:0] got, input logic [17:0] x);
    checks++;
    if (got !== x) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", n, got, x);
    end
  endtask
  task automatic cyc(input string n, input logic [6:0] o, input logic [2:0] f3, input logic rdy, input logic [17:0] x);
    drive(o, f3, 0, 0, rdy);
    #1 chk(n, outs, x);
    @(negedge clk);
  endtask

  initial begin
    rtype(3'b000, 0, 3'b000);
    rtype(3'b000, 1, 3'b001);
    rtype(3'b100, 0, 3'b100);
    rtype(3'b101, 1, 3'b111);
    rtype(3'b111, 0, 3'b010);
    rtype(3'b010, 0, 3'b101);
    itype(3'b000, 1, 3'b000);
    itype(3'b001, 0, 3'b110);
    itype(3'b110, 0, 3'b011);
    v(LW, 3'b010, 0, 0, 0, f_fetch(0, 2'b00));
    v(LW, 3'b010, 0, 0, 0, f_fetch(0, 2'b00));
    v(LW, 3'b010, 0, 0, 1, f_fetch(1, 2'b00));
    v(LW, 3'b010, 0, 0, 1, f_dec(2'b00));
    v(LW, 3'b010, 0, 0, 1, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    for (int i = 0; i < 4; i++)
      v(LW, 3'b010, 0, 0, i == 3, e(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
    v(LW, 3'b010, 0, 0, 1, e(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
    v(BR, 3'b000, 0, 1, 1, f_fetch(1, 2'b10));
    v(BR, 3'b000, 0, 1, 1, f_dec(2'b10));
    v(BR, 3'b000, 0, 1, 1, e(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1, 0));
    v(BR, 3'b001, 0, 1, 1, f_fetch(1, 2'b10));
    v(BR, 3'b001, 0, 1, 1, f_dec(2'b10));
    v(BR, 3'b001, 0, 1, 1, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1, 0));
    v(BR, 3'b001, 0, 0, 1, f_fetch(1, 2'b10));
    v(BR, 3'b001, 0, 0, 1, f_dec(2'b10));
    v(BR, 3'b001, 0, 0, 1, e(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1, 0));
    v(SW, 3'b010, 0, 0, 1, f_fetch(1, 2'b01));
    v(SW, 3'b010, 0, 0, 1, f_dec(2'b01));
    v(SW, 3'b010, 0, 0, 1, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
    for (int i = 0; i < 5; i++)
      v(SW, 3'b010, 0, 0, i == 4, e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, i == 4, 0));
    v(JL, 3'b000, 0, 0, 1, f_fetch(1, 2'b11));
    v(JL, 3'b000, 0, 0, 1, f_dec(2'b11));
    v(JL, 3'b000, 0, 0, 1, e(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
    v(JL, 3'b000, 0, 0, 1, f_wb(2'b11));
    v(RT, 3'b000, 0, 0, 1, f_fetch(1, 2'b00));

    drive(RT, 3'b000, 0, 0, 1);
    #7 chk("reset_state", outs, f_fetch(0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tab[i]) begin
      drive(tab[i].op, tab[i].f3, tab[i].f7, tab[i].z, tab[i].rdy);
      #1 chk($sformatf("vec%0d", i), outs, tab[i].x);
      @(negedge clk);
    end
    // state is DECODE of the trailing R-type fetch; abort it with a reset
    rst_n = 1'b0;
    #1 chk("abort_decode", outs, f_fetch(0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    cyc("bad_fetch", BAD, 3'b000, 1, f_fetch(1, 2'b00));
    cyc("bad_decode", BAD, 3'b000, 1, f_dec(2'b00));
    for (int i = 0; i < 20; i++)
      cyc($sformatf("trap%0d", i), BAD, 3'(i), 1'($urandom_range(0, 1)),
          e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1));
    #2 rst_n = 1'b0;
    #1 chk("trap_reset", outs, f_fetch(0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    cyc("sltu_fetch", RT, 3'b011, 1, f_fetch(1, 2'b00));
    cyc("sltu_decode", RT, 3'b011, 1, f_dec(2'b00));
    drive(RT, 3'b011, 0, 0, 1);
    #1 chk("sltu_exec_en", {13'b0, PCWrite, MemWrite, IRWrite, RegWrite, instr_done}, 18'b0);
    @(negedge clk);
    cyc("sltu_trap", RT, 3'b011, 1, e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1));
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("swr_fetch", SW, 3'b010, 1, f_fetch(1, 2'b01));
    cyc("swr_decode", SW, 3'b010, 1, f_dec(2'b01));
    cyc("swr_memadr", SW, 3'b010, 1, e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
    drive(SW, 3'b010, 0, 0, 0);
    #1 chk("swr_memwrite", outs, e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
    #1 rst_n = 1'b0;
    #1 chk("swr_async_drop", outs, f_fetch(0, 2'b01));
    mem_ready = 1'b1;
    #1 chk("swr_reset_rdy", outs, f_fetch(0, 2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    cyc("swr_restart", SW, 3'b010, 1, f_fetch(1, 2'b01));
    cyc("swr_restart_dec", SW, 3'b010, 1, f_dec(2'b01));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
